// File: rtl/l1c_inst_nway.sv
// l1c_inst_nway: read-only instruction cache, 1- or 2-way set associative, flop-based storage.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   core_addr  fetch address (word aligned, held by the core while core_wait=1)
//   core_req   fetch request
//   flush      one-cycle pulse, invalidates every line
//   core_out   fetched instruction (holds the last delivered value otherwise)
//   core_wait  1 while the result is not yet available
//   I_req      line refill request to memory
//   I_addr     line-aligned refill address
//   I_out      refill data beat
//   I_wait     0 while I_req=1 means I_out carries a valid beat this cycle
module l1c_inst_nway #(
    parameter int unsigned SETS       = 64,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] core_addr,
    input  logic        core_req,
    input  logic        flush,
    output logic [31:0] core_out,
    output logic        core_wait,
    output logic        I_req,
    output logic [31:0] I_addr,
    input  logic [31:0] I_out,
    input  logic        I_wait
);

    localparam int unsigned OFF = $clog2(LINE_WORDS) + 2;
    localparam int unsigned IDX = $clog2(SETS);
    localparam int unsigned TAG = 32 - IDX - OFF;
    localparam int unsigned WW  = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {StIdle, StLookup, StRefill, StResp, StFlush} state_e;

    state_e          state_q;
    logic [31:2]     addr_q;      // address captured when the request is accepted
    logic            way_q;       // victim way of the refill in progress
    logic [WW-1:0]   beat_q;
    logic            pend_q;      // flush seen while an access was in flight
    logic [31:0]     out_q;
    logic            ireq_q;
    logic [31:0]     iaddr_q;
    logic [WAYS-1:0] valid_q [SETS];
    logic [SETS-1:0] lru_q;       // per set: the way to replace next
    logic [TAG-1:0]  tag_q  [SETS][WAYS];
    logic [31:0]     data_q [SETS][WAYS][LINE_WORDS];

    logic [IDX-1:0]  set_idx;
    logic [TAG-1:0]  tag_in;
    logic [WW-1:0]   word_sel;
    logic            hit;
    logic            hit_way;
    logic            victim;
    logic            last_beat;
    logic [31:0]     hit_word;
    logic [31:0]     resp_word;
    logic            unused_addr;

    assign unused_addr = ^core_addr[1:0];
    assign set_idx     = addr_q[IDX+OFF-1:OFF];
    assign tag_in      = addr_q[31:IDX+OFF];
    assign word_sel    = addr_q[OFF-1:2];
    assign last_beat   = (beat_q == WW'(LINE_WORDS - 1));
    assign hit_word    = data_q[set_idx][hit_way][word_sel];
    assign resp_word   = data_q[set_idx][way_q][word_sel];
    assign I_req       = ireq_q;
    assign I_addr      = iaddr_q;

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins over the LRU choice.
    always_comb begin
        victim = (WAYS == 2) ? lru_q[set_idx] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) victim = 1'(w);
        end
    end

    always_comb begin
        core_wait = 1'b1;
        core_out  = out_q;
        unique case (state_q)
            StIdle:   core_wait = core_req;
            StLookup: begin
                core_wait = !hit;
                if (hit) core_out = hit_word;
            end
            StRefill: core_wait = 1'b1;
            StResp: begin
                core_wait = 1'b0;
                core_out  = resp_word;
            end
            StFlush:  core_wait = core_req;
            default:  core_wait = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            way_q   <= 1'b0;
            beat_q  <= '0;
            pend_q  <= 1'b0;
            out_q   <= '0;
            ireq_q  <= 1'b0;
            iaddr_q <= '0;
            lru_q   <= '0;
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (flush) begin
                        state_q <= StFlush;
                    end else if (core_req) begin
                        addr_q  <= core_addr[31:2];
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (hit) begin
                        out_q <= hit_word;
                        if (WAYS == 2) lru_q[set_idx] <= ~hit_way;
                        state_q <= (flush || pend_q) ? StFlush : StIdle;
                    end else begin
                        pend_q  <= pend_q | flush;
                        way_q   <= victim;
                        beat_q  <= '0;
                        ireq_q  <= 1'b1;
                        iaddr_q <= {addr_q[31:OFF], {OFF{1'b0}}};
                        state_q <= StRefill;
                    end
                end
                StRefill: begin
                    pend_q <= pend_q | flush;
                    if (!I_wait) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) begin
                            valid_q[set_idx][way_q] <= 1'b1;
                            ireq_q  <= 1'b0;
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    out_q <= resp_word;
                    if (WAYS == 2) lru_q[set_idx] <= ~way_q;
                    state_q <= (flush || pend_q) ? StFlush : StIdle;
                end
                StFlush: begin
                    for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
                    pend_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag and data arrays need no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (state_q == StRefill && !I_wait) begin
            data_q[set_idx][way_q][beat_q] <= I_out;
            if (last_beat) tag_q[set_idx][way_q] <= tag_in;
        end
    end

endmodule

// File: tb/tb_l1c_inst_nway.sv
module tb_l1c_inst_nway;

    localparam int unsigned SETS = 64;
    localparam int unsigned LW   = 4;
    localparam int unsigned OFF  = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] core_addr;
    logic        core_req;
    logic        flush;
    logic [31:0] core_out;
    logic        core_wait;
    logic        I_req;
    logic [31:0] I_addr;
    logic [31:0] I_out;
    logic        I_wait;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] last_out;

    // Reference model: per set, up to two resident lines ordered by recency.
    logic [31:0] mru_l [SETS];
    logic [31:0] lru_l [SETS];
    int          cnt   [SETS];

    l1c_inst_nway dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .core_addr (core_addr),
        .core_req  (core_req),
        .flush     (flush),
        .core_out  (core_out),
        .core_wait (core_wait),
        .I_req     (I_req),
        .I_addr    (I_addr),
        .I_out     (I_out),
        .I_wait    (I_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if ((a >> 4) == 32'h10) return 32'hA0 + ((a >> 2) & 32'h3);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) cnt[s] = 0;
    endfunction

    function automatic bit model_access(input logic [31:0] a);
        logic [31:0] line;
        int s;
        line = a >> OFF;
        s    = int'(line % SETS);
        if (cnt[s] >= 1 && mru_l[s] == line) return 1'b1;
        if (cnt[s] == 2 && lru_l[s] == line) begin
            lru_l[s] = mru_l[s];
            mru_l[s] = line;
            return 1'b1;
        end
        if (cnt[s] >= 1) lru_l[s] = mru_l[s];
        mru_l[s] = line;
        if (cnt[s] < 2) cnt[s]++;
        return 1'b0;
    endfunction

    // Starts one cycle after the previous access completed (DUT in IDLE).
    task automatic fetch(input logic [31:0] a, input int stall_beat, input int stall_n,
                         input int flush_beat, input int rst_beat);
        bit exp_hit;
        logic [31:0] line;
        int beats;
        int stalled;
        int guard;
        bit pend_flush;
        exp_hit    = model_access(a);
        line       = a & ~32'(LW * 4 - 1);
        beats      = 0;
        stalled    = 0;
        guard      = 0;
        pend_flush = 1'b0;
        @(negedge clk);
        chk("hold_out", core_out, last_out);
        core_addr = a;
        core_req  = 1'b1;
        #1 chk("idle_wait", 32'(core_wait), 32'd1);
        @(negedge clk);
        chk("hit", 32'(!core_wait), 32'(exp_hit));
        if (!core_wait) begin
            chk("hit_data", core_out, mem_val(a));
            chk("hit_noreq", 32'(I_req), 32'd0);
            core_req = 1'b0;
            last_out = mem_val(a);
            return;
        end
        @(negedge clk);
        while (beats < LW && guard < 64) begin
            guard++;
            chk("refill_req", 32'(I_req), 32'd1);
            chk("refill_addr", I_addr, line);
            chk("refill_wait", 32'(core_wait), 32'd1);
            if (beats == rst_beat) begin
                rst_n    = 1'b0;
                core_req = 1'b0;
                I_wait   = 1'b1;
                #1;
                chk("rst_ireq", 32'(I_req), 32'd0);
                chk("rst_iaddr", I_addr, 32'd0);
                chk("rst_out", core_out, 32'd0);
                chk("rst_wait", 32'(core_wait), 32'd0);
                @(negedge clk);
                rst_n    = 1'b1;
                model_clear();
                last_out = '0;
                return;
            end
            if (beats == flush_beat && !pend_flush) begin
                flush      = 1'b1;
                pend_flush = 1'b1;
            end else begin
                flush = 1'b0;
            end
            if (beats == stall_beat && stalled < stall_n) begin
                I_wait = 1'b1;
                I_out  = $urandom;
                stalled++;
            end else begin
                I_wait = 1'b0;
                I_out  = mem_val(line + 32'(4 * beats));
                beats++;
            end
            @(negedge clk);
        end
        flush  = 1'b0;
        I_wait = 1'b1;
        chk("refill_beats", 32'(beats), 32'(LW));
        chk("resp_ireq", 32'(I_req), 32'd0);
        chk("resp_wait", 32'(core_wait), 32'd0);
        chk("resp_data", core_out, mem_val(a));
        core_req = 1'b0;
        last_out = mem_val(a);
        if (pend_flush) begin
            model_clear();
            @(negedge clk);
        end
    endtask

    task automatic flush_idle();
        @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_idle_wait", 32'(core_wait), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_state_wait", 32'(core_wait), 32'd0);
        model_clear();
    endtask

    logic [31:0] tags [4] = '{32'h0, 32'h1, 32'h2, 32'hFFFFF};

    initial begin
        rst_n     = 1'b0;
        core_addr = '0;
        core_req  = 1'b0;
        flush     = 1'b0;
        I_out     = '0;
        I_wait    = 1'b1;
        last_out  = '0;
        model_clear();
        #2;
        chk("reset_out", core_out, 32'd0);
        chk("reset_ireq", 32'(I_req), 32'd0);
        chk("reset_iaddr", I_addr, 32'd0);
        chk("reset_wait0", 32'(core_wait), 32'd0);
        core_req = 1'b1;
        #1 chk("reset_wait1", 32'(core_wait), 32'd1);
        core_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fetch(32'h0000_0104, -1, 0, -1, -1);   // cold miss, expects 0xA1
        fetch(32'h0000_0108, -1, 0, -1, -1);   // hit, expects 0xA2
        fetch(32'h0000_0000, -1, 0, -1, -1);
        fetch(32'h0000_1000, -1, 0, -1, -1);
        fetch(32'h0000_0000, -1, 0, -1, -1);
        fetch(32'h0000_2000, -1, 0, -1, -1);   // evicts 0x1000
        fetch(32'h0000_0000, -1, 0, -1, -1);
        fetch(32'h0000_1000, -1, 0, -1, -1);
        fetch(32'h0000_3008, 2, 3, -1, -1);    // 3 stall cycles before beat 2
        fetch(32'h0000_4004, -1, 0, 2, -1);    // flush during beat 2
        fetch(32'h0000_4004, -1, 0, -1, -1);
        fetch(32'h0000_5000, -1, 0, -1, 1);    // reset during beat 1
        fetch(32'h0000_5000, -1, 0, -1, -1);
        fetch(32'h0000_5000, -1, 0, -1, -1);
        flush_idle();
        fetch(32'h0000_5000, -1, 0, -1, -1);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int sb;
            int fb;
            a  = (tags[$urandom_range(0, 3)] << 12) | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, LW - 1)) << 2);
            sb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            if ($urandom_range(0, 19) == 0) flush_idle();
            fetch(a, sb, int'($urandom_range(1, 3)), fb, -1);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/l1c_inst_nway.md
L1C_INST_NWAY -- requirements
Module: l1c_inst_nway

Interface
REQ-001 SHALL have parameter SETS, default 64: number of sets; power of 2, 4..256.
REQ-002 SHALL have parameter WAYS, default 2: associativity; 1 or 2.
REQ-003 SHALL have parameter LINE_WORDS, default 4: 32-bit words per line; power of 2, 2..8.
REQ-004 Derived widths SHALL be: OFF=log2(LINE_WORDS)+2, IDX=log2(SETS), TAG=32-IDX-OFF.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 core_addr  input  32  fetch address, word aligned; held stable by core while core_wait=1.
REQ-008 core_req  input  1  fetch request.
REQ-009 flush  input  1  one-cycle pulse; invalidates all lines.
REQ-010 core_out  output  32  fetched instruction.
REQ-011 core_wait  output  1  1 = result not yet available.
REQ-012 I_req  output  1  line refill request to memory.
REQ-013 I_addr  output  32  line-aligned refill address {core_addr[31:OFF], OFF'b0}.
REQ-014 I_out  input  32  refill data beat.
REQ-015 I_wait  input  1  0 while I_req=1 = beat on I_out valid this cycle.

Function
REQ-016 Storage SHALL be internal flops: per set/way tag[TAG], valid bit, LINE_WORDS x 32 data; per set one lru bit (used when WAYS=2).
REQ-017 FSM states SHALL be IDLE, LOOKUP, REFILL, RESP, FLUSH.
REQ-018 IDLE: flush=1 -> FLUSH (priority); else core_req=1 -> LOOKUP; core_wait=core_req.
REQ-019 LOOKUP: hit = any way with valid && tag==core_addr[31:IDX+OFF]; on hit core_out=selected word, core_wait=0, lru updated, -> IDLE (hit latency 2 cycles from req).
REQ-020 LOOKUP miss SHALL choose victim: lowest-numbered invalid way, else way indicated by lru; -> REFILL; core_wait=1.
REQ-021 REFILL: I_req=1, I_addr line-aligned, stable; beat counter starts 0, increments on each I_wait=0 cycle; beat k written to word k of victim.
REQ-022 I_wait=1 SHALL stall counter and writes indefinitely; no timeout.
REQ-023 On last beat (counter=LINE_WORDS-1, I_wait=0) victim tag and valid SHALL be written, I_req deasserted next cycle, -> RESP.
REQ-024 RESP: core_out=requested word of filled line, core_wait=0, lru updated, -> IDLE.
REQ-025 LRU update: lru[set] set to the way not accessed; WAYS=1 ignores lru.
REQ-026 FLUSH: all valid bits cleared in one cycle, lru unchanged, -> IDLE; core_wait=core_req.
REQ-027 flush asserted in LOOKUP/REFILL/RESP SHALL be latched as pending; current access completes with valid data, then FLUSH entered instead of servicing next request.
REQ-028 core_out SHALL hold last delivered value in all cycles where core_wait=1 or no request.
REQ-029 Back-to-back requests: a request raised in the IDLE cycle following completion SHALL be accepted.
REQ-030 Index SHALL wrap naturally modulo SETS; addresses differing only above tag bits alias deliberately (none exist).

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, all valid=0, all lru=0, beat counter 0, pending flush 0, core_out=0, I_req=0, I_addr=0.
REQ-032 core_wait during reset SHALL equal core_req (IDLE rule); tag/data contents need not reset.
REQ-033 Reset asserted mid-REFILL SHALL abort refill; partially filled line stays invalid.

Verification
REQ-034 Cold miss: defaults, req 0x0000_0104, memory returns 0xA0,0xA1,0xA2,0xA3 with I_wait=0 -> I_addr=0x0000_0100, 4 beats, core_out=0xA1, core_wait=0 in RESP.
REQ-035 Hit: repeat 0x0000_0108 -> no I_req, core_out=0xA2 in LOOKUP, 2-cycle latency.
REQ-036 Conflict/LRU (WAYS=2): fill 0x0000_0000, 0x0000_1000, hit 0x0000_0000, miss 0x0000_2000 -> victim is way holding 0x1000; 0x0000_0000 still hits.
REQ-037 Stall: I_wait=1 for 3 cycles between beats 1 and 2 -> I_req, I_addr stable, counter frozen, correct data.
REQ-038 Flush mid-refill: flush pulse during beat 2 -> access completes with correct word, FLUSH follows, next fetch of same line misses.
REQ-039 Async reset: rst_n low during REFILL beat 1 -> I_req=0 without clock edge; after release same address misses.
